// File: rtl/divider_pkg.sv
// Shared widths, FSM states and constants for the sequential restoring divider.
package divider_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // All-ones quotient reported when the divisor is zero
  localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module divider_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] diff;

  // The extra top bit of diff acts as the borrow/sign of the trial subtraction
  always_comb begin
    shifted = {rem_in, next_bit};
    diff    = shifted - {2'b00, divisor};
    q_bit   = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/divider_16_bit_seq.sv
// Sequential unsigned 32/16 restoring divider, one quotient bit per clock, start/busy/done handshake.
module divider_16_bit_seq
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = divider_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    part_rem;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  divider_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem_in  (part_rem),
    .next_bit(dvd_q[DIVIDEND_W-1]),
    .divisor (dsr),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign busy = (state != IDLE);

  // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB,
  // so after the last step it holds the full quotient.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      part_rem    <= '0;
      dvd_q       <= '0;
      dsr         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q    <= dividend;
            dsr      <= divisor;
            part_rem <= '0;
            cnt      <= '0;
            state    <= (divisor == '0) ? FINISH : RUN;
          end
        end
        RUN: begin
          part_rem <= step_rem;
          dvd_q    <= {dvd_q[DIVIDEND_W-2:0], step_q};
          cnt      <= cnt + 1'b1;
          if (cnt == LAST_STEP) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
          if (dsr == '0) begin
            quotient    <= DIVIDEND_W'(DIV0_QUOTIENT);
            remainder   <= dvd_q[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= dvd_q;
            remainder   <= part_rem[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16_bit_seq.sv
// Directed and randomized checks of the sequential divider: latency, results, div-by-zero, handshake and reset.
module tb_divider_16_bit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int vectors;
  int miscompares;

  divider_16_bit_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called #1 after an edge with busy low; the next edge is the accepting edge E0.
  task automatic launch(input logic [31:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0003;
  endtask

  // Counts edges until done is seen high; returns 999 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) return;
    end
    edges = 999;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 51'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int edges;
    launch(32'd9173160, 16'd1660);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_busy: got %b, want 1", busy);
    end
    wait_done(edges);
    vectors++;
    if (edges !== 33) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d edges, want 33", edges);
    end
    vectors++;
    if ({quotient, remainder, div_by_zero, busy} !== {32'd5526, 16'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL basic_result: got q=%0d r=%0d dz=%b busy=%b, want q=5526 r=0 dz=0 busy=0",
               quotient, remainder, div_by_zero, busy);
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({done, quotient} !== {1'b0, 32'd5526}) begin
      miscompares++;
      $display("[TB] FAIL basic_hold: got done=%b q=%0d, want done=0 q=5526", done, quotient);
    end
  endtask

  task automatic test_large();
    int edges;
    launch(32'd4294836225, 16'd65535);
    wait_done(edges);
    vectors++;
    if ({quotient, remainder} !== {32'd65535, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL large_result: got q=%0d r=%0d, want q=65535 r=0", quotient, remainder);
    end
    @(posedge clk);
    #1;
    launch(32'd100, 16'd7);
    wait_done(edges);
    vectors++;
    if ({quotient, remainder, edges} !== {32'd14, 16'd2, 32'd33}) begin
      miscompares++;
      $display("[TB] FAIL small_result: got q=%0d r=%0d edges=%0d, want q=14 r=2 edges=33",
               quotient, remainder, edges);
    end
  endtask

  task automatic test_div_zero();
    int edges;
    @(posedge clk);
    #1;
    launch(32'h0001_2345, 16'd0);
    wait_done(edges);
    vectors++;
    if (edges !== 1) begin
      miscompares++;
      $display("[TB] FAIL div0_latency: got %0d edges, want 1", edges);
    end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 16'h2345, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL div0_result: got q=%h r=%h dz=%b, want q=ffffffff r=2345 dz=1",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_ignored();
    int edges;
    @(posedge clk);
    #1;
    launch(32'd120, 16'd10);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; dividend = 32'd50; divisor = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(edges);
    vectors++;
    if ({quotient, remainder, div_by_zero, edges} !== {32'd12, 16'd0, 1'b0, 32'd27}) begin
      miscompares++;
      $display("[TB] FAIL ignored_start: got q=%0d r=%0d dz=%b edges=%0d, want q=12 r=0 dz=0 edges=27",
               quotient, remainder, div_by_zero, edges);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    // Still in the done cycle of the previous operation
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_precond: got done=%b, want 1", done);
    end
    launch(32'd50, 16'd5);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    wait_done(edges);
    vectors++;
    if ({quotient, remainder, edges + 1} !== {32'd10, 16'd0, 32'd34}) begin
      miscompares++;
      $display("[TB] FAIL b2b_result: got q=%0d r=%0d cycles=%0d, want q=10 r=0 cycles=34",
               quotient, remainder, edges + 1);
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    bit saw_done;
    @(posedge clk);
    #1;
    launch(32'd250, 16'd11);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 51'd0) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrun_no_done: got done pulse=%b, want 0", saw_done);
    end
    launch(32'd250, 16'd11);
    wait_done(edges);
    vectors++;
    if ({quotient, remainder, edges} !== {32'd22, 16'd8, 32'd33}) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got q=%0d r=%0d edges=%0d, want q=22 r=8 edges=33",
               quotient, remainder, edges);
    end
  endtask

  task automatic test_random();
    int edges;
    logic [31:0] a;
    logic [15:0] b;
    logic [47:0] recon;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = 16'($urandom_range(1, 65535));
      if (i == 0) b = 16'd1;
      if (i == 1) a = 32'd0;
      if (i == 2) b = 16'($urandom_range(1, 15));
      @(posedge clk);
      #1;
      launch(a, b);
      wait_done(edges);
      recon = 48'(quotient) * 48'(b) + 48'(remainder);
      vectors++;
      if ({quotient, remainder, div_by_zero} !== {a / 32'(b), 16'(a % 32'(b)), 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rand_model %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=0",
                 a, b, quotient, remainder, div_by_zero, a / 32'(b), a % 32'(b));
      end
      vectors++;
      if ((recon !== 48'(a)) || (remainder >= b)) begin
        miscompares++;
        $display("[TB] FAIL rand_identity %0d/%0d: got q*d+r=%0d r=%0d, want %0d with r<%0d",
                 a, b, recon, remainder, a, b);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_large();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
